// File: rtl/serial_word_pkg.sv
// Shared types and constants for the serial word deserializer.
// SERIAL_WORD_PARITY_CHECK_EN adds a trailing even-parity bit per word.
package serial_word_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        PARITY  = 2'd2
    } state_t;

    // Counter must hold values 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_out_buffer.sv
// Output holding register: valid/ready handshake, drop-on-full and sticky overrun.
// SERIAL_WORD_PARITY_CHECK_EN adds a parity error flag that travels with the word.
module serial_word_out_buffer
    import serial_word_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  word_done,
    input  logic [DATA_WIDTH-1:0] word,
`ifdef SERIAL_WORD_PARITY_CHECK_EN
    input  logic                  word_perr,
    output logic                  parity_err,
`endif
    input  logic                  ready,
    input  logic                  overrun_clear,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  overrun
);

    logic transfer;
    logic can_load;
    logic drop;

    always_comb begin
        transfer = valid & ready;
        can_load = ~valid | transfer;
        drop     = word_done & ~can_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
`ifdef SERIAL_WORD_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (word_done && can_load) begin
                data  <= word;
                valid <= 1'b1;
`ifdef SERIAL_WORD_PARITY_CHECK_EN
                parity_err <= word_perr;
`endif
            end else if (transfer) begin
                valid <= 1'b0;
`ifdef SERIAL_WORD_PARITY_CHECK_EN
                parity_err <= 1'b0;
`endif
            end

            // A new drop takes priority over a simultaneous clear.
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// MSB-first serial-to-parallel word assembler with registered valid/ready output.
// Define SERIAL_WORD_PARITY_CHECK_EN to expect an even-parity bit after each word.
module serial_word_deserializer
    import serial_word_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Serial_Data_In,
    input  logic                  Serial_Valid_In,
    input  logic                  Frame_Start_In,
    input  logic                  Data_Ready_In,
    input  logic                  Overrun_Clear_In,
    output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
    output logic                  Data_Valid_Out,
    output logic                  Overrun_Error_Out,
    output logic                  Busy_Out
`ifdef SERIAL_WORD_PARITY_CHECK_EN
    ,
    output logic                  Parity_Error_Out
`endif
);

    localparam int unsigned CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_DATA_COUNT = CW'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [CW-1:0]         count;
    logic                  bit_accept;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] word;
`ifdef SERIAL_WORD_PARITY_CHECK_EN
    logic                  word_perr;
`endif

    always_comb begin
        bit_accept = Enable_In & Serial_Valid_In;
        shift_next = {shift[DATA_WIDTH-2:0], Serial_Data_In};
    end

    // Completed words are registered here, giving one clock of latency into the buffer.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state     <= IDLE;
            shift     <= '0;
            count     <= '0;
            word_done <= 1'b0;
            word      <= '0;
            Busy_Out  <= 1'b0;
`ifdef SERIAL_WORD_PARITY_CHECK_EN
            word_perr <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            if (bit_accept) begin
                if (Frame_Start_In) begin
                    // Resync from any state: drop the partial word silently.
                    shift    <= {{(DATA_WIDTH-1){1'b0}}, Serial_Data_In};
                    count    <= CW'(1);
                    state    <= RECEIVE;
                    Busy_Out <= 1'b1;
                end else begin
                    case (state)
                        RECEIVE: begin
                            shift <= shift_next;
                            if (count == LAST_DATA_COUNT) begin
`ifdef SERIAL_WORD_PARITY_CHECK_EN
                                count <= CW'(DATA_WIDTH);
                                state <= PARITY;
`else
                                count     <= '0;
                                state     <= IDLE;
                                Busy_Out  <= 1'b0;
                                word_done <= 1'b1;
                                word      <= shift_next;
`endif
                            end else begin
                                count <= count + CW'(1);
                            end
                        end
`ifdef SERIAL_WORD_PARITY_CHECK_EN
                        PARITY: begin
                            count     <= '0;
                            state     <= IDLE;
                            Busy_Out  <= 1'b0;
                            word_done <= 1'b1;
                            word      <= shift;
                            word_perr <= (^shift) ^ Serial_Data_In;
                        end
`endif
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    serial_word_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buffer (
        .clk           (Clk_In),
        .reset         (Reset_In),
        .word_done     (word_done),
        .word          (word),
`ifdef SERIAL_WORD_PARITY_CHECK_EN
        .word_perr     (word_perr),
        .parity_err    (Parity_Error_Out),
`endif
        .ready         (Data_Ready_In),
        .overrun_clear (Overrun_Clear_In),
        .data          (Parallel_Data_Out),
        .valid         (Data_Valid_Out),
        .overrun       (Overrun_Error_Out)
    );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer: directed frames plus random traffic vs a bit-queue model.
// Honours SERIAL_WORD_PARITY_CHECK_EN to match the DUT build.
module tb_serial_word_deserializer;

    localparam int unsigned W = 4;
`ifdef SERIAL_WORD_PARITY_CHECK_EN
    localparam int unsigned FRAME_LEN = W + 1;
`else
    localparam int unsigned FRAME_LEN = W;
`endif

    logic         Clk_In = 1'b0;
    logic         Reset_In = 1'b1;
    logic         Enable_In = 1'b0;
    logic         Serial_Data_In = 1'b0;
    logic         Serial_Valid_In = 1'b0;
    logic         Frame_Start_In = 1'b0;
    logic         Data_Ready_In = 1'b0;
    logic         Overrun_Clear_In = 1'b0;
    logic [W-1:0] Parallel_Data_Out;
    logic         Data_Valid_Out;
    logic         Overrun_Error_Out;
    logic         Busy_Out;
`ifdef SERIAL_WORD_PARITY_CHECK_EN
    logic         Parity_Error_Out;
`endif

    always #5 Clk_In = ~Clk_In;

    serial_word_deserializer #(
        .DATA_WIDTH (W)
    ) dut (
        .Clk_In            (Clk_In),
        .Reset_In          (Reset_In),
        .Enable_In         (Enable_In),
        .Serial_Data_In    (Serial_Data_In),
        .Serial_Valid_In   (Serial_Valid_In),
        .Frame_Start_In    (Frame_Start_In),
        .Data_Ready_In     (Data_Ready_In),
        .Overrun_Clear_In  (Overrun_Clear_In),
        .Parallel_Data_Out (Parallel_Data_Out),
        .Data_Valid_Out    (Data_Valid_Out),
        .Overrun_Error_Out (Overrun_Error_Out),
`ifdef SERIAL_WORD_PARITY_CHECK_EN
        .Parity_Error_Out  (Parity_Error_Out),
`endif
        .Busy_Out          (Busy_Out)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference model: bits of the frame in flight, one word waiting to surface, output view.
    bit           m_active = 1'b0;
    bit           m_bits[$];
    bit           m_pend = 1'b0;
    logic [W-1:0] m_pend_word = '0;
    bit           m_pend_perr = 1'b0;
    logic [W-1:0] m_data = '0;
    bit           m_valid = 1'b0;
    bit           m_ovr = 1'b0;
    bit           m_perr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit          xfer;
        bit          ovr_set;
        int unsigned w;
        bit          p;
        if (Reset_In) begin
            m_active = 1'b0;
            m_bits.delete();
            m_pend = 1'b0;
            m_pend_word = '0;
            m_pend_perr = 1'b0;
            m_data = '0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
            m_perr = 1'b0;
        end else begin
            xfer = m_valid && Data_Ready_In;
            ovr_set = 1'b0;
            if (m_pend) begin
                if (!m_valid || xfer) begin
                    m_data = m_pend_word;
                    m_valid = 1'b1;
                    m_perr = m_pend_perr;
                end else begin
                    ovr_set = 1'b1;
                end
            end else if (xfer) begin
                m_valid = 1'b0;
                m_perr = 1'b0;
            end
            if (ovr_set) m_ovr = 1'b1;
            else if (Overrun_Clear_In) m_ovr = 1'b0;
            m_pend = 1'b0;

            if (Enable_In && Serial_Valid_In) begin
                if (Frame_Start_In) begin
                    m_bits.delete();
                    m_bits.push_back(Serial_Data_In);
                    m_active = 1'b1;
                end else if (m_active) begin
                    m_bits.push_back(Serial_Data_In);
                end
                if (m_active && m_bits.size() == FRAME_LEN) begin
                    w = 0;
                    p = 1'b0;
                    for (int i = 0; i < int'(W); i++) w = w * 2 + int'(m_bits[i]);
                    for (int i = 0; i < m_bits.size(); i++) p ^= m_bits[i];
                    m_pend_word = w[W-1:0];
                    m_pend_perr = p;
                    m_pend = 1'b1;
                    m_active = 1'b0;
                    m_bits.delete();
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("data", 32'(Parallel_Data_Out), 32'(m_data));
        check_eq("valid", 32'(Data_Valid_Out), 32'(m_valid));
        check_eq("overrun", 32'(Overrun_Error_Out), 32'(m_ovr));
        check_eq("busy", 32'(Busy_Out), 32'(m_active));
`ifdef SERIAL_WORD_PARITY_CHECK_EN
        check_eq("parity_err", 32'(Parity_Error_Out), 32'(m_perr));
`endif
    endtask

    task automatic step(input logic en, input logic sv, input logic sd, input logic fs,
                        input logic rdy, input logic clr, input logic rst);
        Enable_In = en;
        Serial_Valid_In = sv;
        Serial_Data_In = sd;
        Frame_Start_In = fs;
        Data_Ready_In = rdy;
        Overrun_Clear_In = clr;
        Reset_In = rst;
        @(posedge Clk_In);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic send_bit(input logic sd, input logic fs, input logic rdy);
        step(1'b1, 1'b1, sd, fs, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        step(1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    task automatic send_parity(input logic [W-1:0] word, input logic rdy);
`ifdef SERIAL_WORD_PARITY_CHECK_EN
        send_bit(^word, 1'b0, rdy);
`else
        if (word === 'x && rdy === 1'bx) $display("unexpected unknown stimulus");
`endif
    endtask

    task automatic send_word(input logic [W-1:0] word, input logic rdy);
        for (int i = W - 1; i >= 0; i--) send_bit(word[i], i == int'(W - 1), rdy);
        send_parity(word, rdy);
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("rst_data", 32'(Parallel_Data_Out), 32'h0);
        check_eq("rst_valid", 32'(Data_Valid_Out), 32'h0);
        check_eq("rst_overrun", 32'(Overrun_Error_Out), 32'h0);
        check_eq("rst_busy", 32'(Busy_Out), 32'h0);

        // Single word, one-clock latency, valid for exactly one cycle
        send_word(4'b1011, 1'b1);
        check_eq("t1_latency", 32'(Data_Valid_Out), 32'h0);
        idle(1'b1);
        check_eq("t1_data", 32'(Parallel_Data_Out), 32'hb);
        check_eq("t1_valid", 32'(Data_Valid_Out), 32'h1);
        idle(1'b1);
        check_eq("t1_valid_fall", 32'(Data_Valid_Out), 32'h0);

        // Overrun while the consumer stalls, then clear and drain
        send_word(4'b0110, 1'b0);
        idle(1'b0);
        send_word(4'b1001, 1'b0);
        idle(1'b0);
        check_eq("t2_hold", 32'(Parallel_Data_Out), 32'h6);
        check_eq("t2_overrun", 32'(Overrun_Error_Out), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t2_clear", 32'(Overrun_Error_Out), 32'h0);
        idle(1'b1);
        check_eq("t2_drain", 32'(Data_Valid_Out), 32'h0);

        // Resync mid-frame
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_word(4'b0010, 1'b1);
        idle(1'b1);
        check_eq("t3_data", 32'(Parallel_Data_Out), 32'h2);
        check_eq("t3_overrun", 32'(Overrun_Error_Out), 32'h0);

        // Enable low mid-word ignores strobes, including frame starts
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, logic'(i % 2 == 0), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t4_busy", 32'(Busy_Out), 32'h1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_parity(4'b1110, 1'b1);
        idle(1'b1);
        check_eq("t4_data", 32'(Parallel_Data_Out), 32'he);

        // Reset mid-frame, with an overrun pending
        send_word(4'b0001, 1'b0);
        send_word(4'b0011, 1'b0);
        idle(1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t5_data", 32'(Parallel_Data_Out), 32'h0);
        check_eq("t5_valid", 32'(Data_Valid_Out), 32'h0);
        check_eq("t5_overrun", 32'(Overrun_Error_Out), 32'h0);
        check_eq("t5_busy", 32'(Busy_Out), 32'h0);
        send_word(4'b1110, 1'b1);
        idle(1'b1);
        check_eq("t5_word", 32'(Parallel_Data_Out), 32'he);

`ifdef SERIAL_WORD_PARITY_CHECK_EN
        // Parity: flag is XOR of the data bits and the parity bit
        for (int i = W - 1; i >= 0; i--) send_bit(logic'((4'b1011 >> i) & 4'b1), i == int'(W - 1), 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        idle(1'b1);
        check_eq("t6_perr_good", 32'(Parity_Error_Out), 32'h0);
        for (int i = W - 1; i >= 0; i--) send_bit(logic'((4'b1011 >> i) & 4'b1), i == int'(W - 1), 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        idle(1'b1);
        check_eq("t6_perr_bad", 32'(Parity_Error_Out), 32'h1);
        check_eq("t6_data", 32'(Parallel_Data_Out), 32'hb);
`endif

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(logic'($urandom_range(7) != 0), logic'($urandom_range(1)),
                 logic'($urandom_range(1)), logic'($urandom_range(5) == 0),
                 logic'($urandom_range(2) != 0), logic'($urandom_range(9) == 0),
                 logic'($urandom_range(199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
